// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Brief    : Streams a range of register-file words as bytes, MSB first,
//            over a valid/ready byte interface. Define DUMP_HEADER_EN to
//            prefix each dump with a 0xA5 header byte.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  read_address_debug,
  input  logic [31:0] data_in_debug,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] C_FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] C_LAST_ADDR  = 5'(LAST_REG);

  localparam logic [2:0] S_IDLE    = 3'd0;
`ifdef DUMP_HEADER_EN
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [7:0] C_HEADER  = 8'hA5;
`endif
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_byte;
  logic        last_word;

  assign last_byte = (cnt_q == 2'd3);
  assign last_word = (addr_q == C_LAST_ADDR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= C_FIRST_ADDR;
      shift_q <= 32'h0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef DUMP_HEADER_EN
          state_d = S_HEADER;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef DUMP_HEADER_EN
      S_HEADER:  if (byte_ready) state_d = S_FETCH;
`endif
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_SEND;
      S_SEND: begin
        if (byte_ready && last_byte) begin
          state_d = last_word ? S_FINISH : S_FETCH;
        end
      end
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The address only advances on the last byte of a non-final word, so it
  // can never pass LAST_REG or wrap.
  always_comb begin
    addr_d  = addr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) addr_d = C_FIRST_ADDR;
      end
      S_CAPTURE: begin
        shift_d = data_in_debug;
        cnt_d   = 2'd0;
      end
      S_SEND: begin
        if (byte_ready) begin
          shift_d = {shift_q[23:0], 8'h00};
          cnt_d   = cnt_q + 2'd1;
          if (last_byte && !last_word) addr_d = addr_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    byte_out   = 8'h00;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_FINISH);
    case (state_q)
      S_SEND: begin
        byte_valid = 1'b1;
        byte_out   = shift_q[31:24];
      end
`ifdef DUMP_HEADER_EN
      S_HEADER: begin
        byte_valid = 1'b1;
        byte_out   = C_HEADER;
      end
`endif
      default: ;
    endcase
  end

  assign read_address_debug = addr_q;

endmodule
`default_nettype wire
